// File: rtl/dcache_ctrl_rv32_pkg.sv
// dcache_ctrl_rv32_pkg
// Types and helpers shared by the data-cache controller files.
//   state_e    : controller FSM state, encodings from dcache_defs.vh
//   BE_FULL    : byte enables for a whole 32-bit word
//   word_align : clears the byte-offset bits of an address
package dcache_ctrl_rv32_pkg;

`include "dcache_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE   = `DCACHE_ST_IDLE,
        ST_REFILL = `DCACHE_ST_REFILL,
        ST_WRITE  = `DCACHE_ST_WRITE,
        ST_WDONE  = `DCACHE_ST_WDONE
    } state_e;

    localparam logic [3:0] BE_FULL = `DCACHE_BE_FULL;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dcache_ctrl_rv32_if.sv
// dcache_ctrl_rv32_if
// Bundles the requester (memory-access stage) and backing-memory signals
// of the data cache.
//   modport slave  : the cache controller side
//   modport master : the environment side (pipeline stage + memory)
// Requester: iREQ, iRW (1=read), iADDR, iWDATA, iBE -> oRDATA, oStallD
// Memory   : oMemREQ, oMemWE, oMemADDR, oMemWDATA, oMemBE <- iMemACK, iMemRDATA
interface dcache_ctrl_rv32_if;
    logic        iREQ;
    logic        iRW;
    logic [31:0] iADDR;
    logic [31:0] iWDATA;
    logic [3:0]  iBE;
    logic [31:0] oRDATA;
    logic        oStallD;
    logic        oMemREQ;
    logic        oMemWE;
    logic [31:0] oMemADDR;
    logic [31:0] oMemWDATA;
    logic [3:0]  oMemBE;
    logic        iMemACK;
    logic [31:0] iMemRDATA;

    modport slave (
        input  iREQ, iRW, iADDR, iWDATA, iBE, iMemACK, iMemRDATA,
        output oRDATA, oStallD, oMemREQ, oMemWE, oMemADDR, oMemWDATA, oMemBE
    );

    modport master (
        output iREQ, iRW, iADDR, iWDATA, iBE, iMemACK, iMemRDATA,
        input  oRDATA, oStallD, oMemREQ, oMemWE, oMemADDR, oMemWDATA, oMemBE
    );
endinterface

// File: rtl/dcache_array_rv32.sv
// dcache_array_rv32
// Direct-mapped tag/valid/data storage, one 32-bit word per line.
//   iCLK, iRST      : clock, synchronous active-high reset (valid bits only)
//   rd_idx_i        : combinational lookup index
//   rd_valid_o/rd_tag_o/rd_data_o : contents of the indexed line
//   wr_en_i         : write strobe; writes tag, sets valid, merges bytes
//   wr_idx_i/wr_tag_i/wr_data_i/wr_be_i : write port
module dcache_array_rv32
    import dcache_ctrl_rv32_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i,
    input  logic [3:0]       wr_be_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; an invalid line is never reported as a hit.
    always_ff @(posedge iCLK) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_defs.vh
// dcache_defs.vh
// Shared encodings for the RV32 data-cache controller:
//   - FSM state codes (IDLE, REFILL, WRITE, WDONE)
//   - full-word byte-enable constant used for line refills
`ifndef DCACHE_DEFS_VH
`define DCACHE_DEFS_VH

`define DCACHE_ST_IDLE   2'd0
`define DCACHE_ST_REFILL 2'd1
`define DCACHE_ST_WRITE  2'd2
`define DCACHE_ST_WDONE  2'd3

`define DCACHE_BE_FULL   4'hF

`endif

// File: rtl/dcache_ctrl_rv32.sv
// dcache_ctrl_rv32
// RV32 data-cache controller: direct-mapped, one word per line,
// write-through / no-write-allocate, blocking (one access in flight).
//   iCLK, iRST : clock, synchronous active-high reset
//   bus        : dcache_ctrl_rv32_if.slave (requester + backing memory)
//   oHitCnt, oMissCnt : saturating IDLE read hit/miss counters, present
//                       only when DCACHE_STATS_EN is defined
// Read hits return in the same cycle; a read miss refills the line and
// returns through a re-lookup in IDLE; every store goes to memory and
// finishes with a one-cycle WDONE release.
module dcache_ctrl_rv32
    import dcache_ctrl_rv32_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    dcache_ctrl_rv32_if.slave  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        oHitCnt,
    output logic [31:0]        oMissCnt
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    state_e      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [29:0]      lk_word_d;
    logic [IDX_W-1:0] lk_idx_d;
    logic [TAG_W-1:0] lk_tag_d;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             hit_d;
    logic             idle_rd_d, idle_wr_d, rd_hit_d, rd_miss_d;
    logic             ack_fill_d, ack_wr_d;
    logic             arr_we_d;

    // In IDLE the lookup follows the live request; otherwise it follows the
    // latched address so the write-hit check sees the line being stored to.
    assign lk_word_d = (state_q == ST_IDLE) ? bus.iADDR[31:2] : addr_q[31:2];
    assign lk_idx_d  = lk_word_d[IDX_W-1:0];
    assign lk_tag_d  = lk_word_d[29:IDX_W];
    assign hit_d     = line_valid && (line_tag == lk_tag_d);

    assign idle_rd_d = (state_q == ST_IDLE) && bus.iREQ && bus.iRW;
    assign idle_wr_d = (state_q == ST_IDLE) && bus.iREQ && !bus.iRW;
    assign rd_hit_d  = idle_rd_d && hit_d;
    assign rd_miss_d = idle_rd_d && !hit_d;

    assign ack_fill_d = (state_q == ST_REFILL) && bus.iMemACK;
    assign ack_wr_d   = (state_q == ST_WRITE) && bus.iMemACK;
    // A reset landing on the ack edge wins: the access is aborted, not committed.
    assign arr_we_d   = !iRST && (ack_fill_d || (ack_wr_d && hit_d));

    dcache_array_rv32 #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .rd_idx_i   (lk_idx_d),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (arr_we_d),
        .wr_idx_i   (addr_q[IDX_W+1:2]),
        .wr_tag_i   (addr_q[31:IDX_W+2]),
        .wr_data_i  (ack_fill_d ? bus.iMemRDATA : wdata_q),
        .wr_be_i    (ack_fill_d ? BE_FULL : be_q)
    );

    assign bus.oRDATA    = rd_hit_d ? line_data : 32'h0;
    assign bus.oStallD   = (state_q == ST_REFILL) || (state_q == ST_WRITE) ||
                           rd_miss_d || idle_wr_d;
    assign bus.oMemREQ   = mem_req_q;
    assign bus.oMemWE    = mem_we_q;
    assign bus.oMemADDR  = addr_q;
    assign bus.oMemWDATA = wdata_q;
    assign bus.oMemBE    = be_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rd_miss_d) begin
                        addr_q    <= word_align(bus.iADDR);
                        be_q      <= BE_FULL;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_REFILL;
                    end else if (idle_wr_d) begin
                        addr_q    <= word_align(bus.iADDR);
                        wdata_q   <= bus.iWDATA;
                        be_q      <= bus.iBE;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_REFILL: begin
                    if (bus.iMemACK) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (bus.iMemACK) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_WDONE;
                    end
                end
                ST_WDONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (rd_hit_d && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (rd_miss_d && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign oHitCnt  = hit_cnt_q;
    assign oMissCnt = miss_cnt_q;
`endif

endmodule
